// File: rtl/rot_cipher.sv
`default_nettype none
// ============================================================================
// Module   : rot_cipher
// Brief    : Multi-round key-rotation cipher, one round per clock, req/rdy I/O.
//            Decrypt datapath built only when ENCRYPTER_DECRYPT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rot_cipher #(
    parameter int DATA_WIDTH = 16,
    parameter int ROT_WIDTH  = 4,
    parameter int ROUNDS     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ROT_WIDTH-1:0]  rot_offset,
    input  logic                  mode,
    input  logic                  prog,
    input  logic                  rdyIn,
    input  logic                  rdyOut,
    output logic                  reqIn,
    output logic                  reqOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic [1:0]            state,
    output logic [DATA_WIDTH-1:0] key
);

    localparam int c_CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_ROUND = c_CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_key;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [ROT_WIDTH-1:0]  r_offset;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [c_CNT_W-1:0]    w_idx;
    logic [ROT_WIDTH-1:0]  w_step;
    logic [ROT_WIDTH-1:0]  w_amt;
    logic [DATA_WIDTH-1:0] w_rkey;
    logic [DATA_WIDTH-1:0] w_enc;
    logic [DATA_WIDTH-1:0] w_round;
    logic                  w_last;

    function automatic logic [DATA_WIDTH-1:0] f_rotl(
        input logic [DATA_WIDTH-1:0] x,
        input logic [ROT_WIDTH-1:0]  s
    );
        logic [2*DATA_WIDTH-1:0] t;
        t = {x, x} << s;
        return t[2*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction

    assign w_last = (r_cnt == c_LAST_ROUND);

`ifdef ENCRYPTER_DECRYPT_EN
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] w_dec;

    // Decrypt walks the round keys backwards so it undoes encrypt round by round.
    assign w_idx   = r_mode ? (c_LAST_ROUND - r_cnt) : r_cnt;
    assign w_dec   = {r_data[0], r_data[DATA_WIDTH-1:1]} ^ w_rkey;
    assign w_round = r_mode ? w_dec : w_enc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 1'b0;
        end else if (r_state == S_IDLE && rdyIn && !prog) begin
            r_mode <= mode;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_idx         = r_cnt;
    assign w_round       = w_enc;
`endif

    // Product is truncated to ROT_WIDTH bits, i.e. taken modulo DATA_WIDTH.
    assign w_step = ROT_WIDTH'(w_idx) + ROT_WIDTH'(1);
    assign w_amt  = w_step * r_offset;
    assign w_rkey = f_rotl(r_key, w_amt);
    assign w_enc  = f_rotl(r_data ^ w_rkey, ROT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (rdyIn && !prog) w_next = S_ROUND;
            S_ROUND: if (w_last)         w_next = S_DONE;
            S_DONE:  if (rdyOut)         w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key    <= '0;
            r_data   <= '0;
            r_dout   <= '0;
            r_offset <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rdyIn && prog) begin
                        r_key <= dataIn;
                    end else if (rdyIn) begin
                        r_data   <= dataIn;
                        r_offset <= rot_offset;
                        r_cnt    <= '0;
                    end
                end
                S_ROUND: begin
                    r_data <= w_round;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_dout <= w_round;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reqIn   = (r_state == S_IDLE);
    assign reqOut  = (r_state == S_DONE);
    assign dataOut = r_dout;
    assign state   = r_state;
    assign key     = r_key;

endmodule
`default_nettype wire

// File: tb/tb_rot_cipher.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for rot_cipher: directed vectors plus randomized words against a
// behavioural model built from the round equations.
module tb_rot_cipher;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dataIn;
    logic [RW-1:0] rot_offset;
    logic          mode;
    logic          prog;
    logic          rdyIn;
    logic          rdyOut;
    logic          reqIn;
    logic          reqOut;
    logic [DW-1:0] dataOut;
    logic [1:0]    state;
    logic [DW-1:0] key;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rot_cipher #(.DATA_WIDTH(DW), .ROT_WIDTH(RW), .ROUNDS(NR)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .rot_offset(rot_offset),
        .mode(mode), .prog(prog), .rdyIn(rdyIn), .rdyOut(rdyOut),
        .reqIn(reqIn), .reqOut(reqOut), .dataOut(dataOut), .state(state), .key(key)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_rotl(input logic [DW-1:0] x, input int n);
        int s;
        s = n % DW;
        if (s == 0) return x;
        return (x << s) | (x >> (DW - s));
    endfunction

    function automatic logic [DW-1:0] m_rotr(input logic [DW-1:0] x, input int n);
        return m_rotl(x, DW - (n % DW));
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [DW-1:0] k,
                                            input int off, input bit dec);
        logic [DW-1:0] v;
        v = d;
        if (!dec) begin
            for (int i = 0; i < NR; i++) v = m_rotl(v ^ m_rotl(k, (i + 1) * off), 1);
        end else begin
            for (int i = NR - 1; i >= 0; i--) v = m_rotr(v, 1) ^ m_rotl(k, (i + 1) * off);
        end
        return v;
    endfunction

    function automatic bit dec_effective(input bit md);
`ifdef ENCRYPTER_DECRYPT_EN
        return md;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] off,
                        input logic md, input logic pg);
        int guard = 0;
        while (!reqIn && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("send_ready", {31'd0, reqIn}, 32'd1);
        dataIn = d; rot_offset = off; mode = md; prog = pg; rdyIn = 1'b1;
        @(posedge clk); #1;
        rdyIn = 1'b0; prog = 1'b0;
    endtask

    task automatic await_result(input string tag, input logic [DW-1:0] exp);
        int lat = 0;
        while (!reqOut && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, NR);
        check({tag, "_data"}, {16'd0, dataOut}, {16'd0, exp});
    endtask

    task automatic take_output(input string tag);
        rdyOut = 1'b1;
        @(posedge clk); #1;
        rdyOut = 1'b0;
        check({tag, "_idle"}, {30'd0, state}, 32'd0);
        check({tag, "_reqIn"}, {31'd0, reqIn}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] m_key, d, exp, held;
        logic [RW-1:0] off;
        logic          md;

        reset = 1'b1; dataIn = '0; rot_offset = '0; mode = 1'b0; prog = 1'b0;
        rdyIn = 1'b0; rdyOut = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_reqIn", {31'd0, reqIn}, 32'd1);
        check("rst_reqOut", {31'd0, reqOut}, 32'd0);
        check("rst_dataOut", {16'd0, dataOut}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_key", {16'd0, key}, 32'd0);

        // Zero key: pure rotation.
        send(16'hF0F0, 4'd7, 1'b0, 1'b0);
        check("t1_reqIn_fall", {31'd0, reqIn}, 32'd0);
        await_result("t1", 16'hC3C3);
        take_output("t1");

        // Key load then data on the very next edge.
        send(16'h0001, 4'd0, 1'b0, 1'b1);
        check("t2_key", {16'd0, key}, 32'h0001);
        check("t2_reqIn", {31'd0, reqIn}, 32'd1);
        check("t2_state", {30'd0, state}, 32'd0);
        send(16'h0000, 4'd4, 1'b0, 1'b0);
        await_result("t2", 16'h0240);
        take_output("t2");

`ifdef ENCRYPTER_DECRYPT_EN
        exp = 16'h0000;
`else
        exp = 16'h0B40;
`endif
        send(16'h0240, 4'd4, 1'b1, 1'b0);
        await_result("t3_mode", exp);
        take_output("t3");

        // rdyOut already high on DONE entry: one-cycle DONE.
        rdyOut = 1'b1;
        send(16'h0000, 4'd15, 1'b0, 1'b0);
        await_result("t4_wrap", 16'h8002);
        @(posedge clk); #1;
        rdyOut = 1'b0;
        check("t4_done_1cyc", {30'd0, state}, 32'd0);

        // Stall in DONE with ignored rdyIn/prog pulses.
        exp = model(16'h1234, 16'h0001, 3, 1'b0);
        send(16'h1234, 4'd3, 1'b0, 1'b0);
        await_result("t5", exp);
        for (int i = 0; i < 10; i++) begin
            dataIn = DW'($urandom); rdyIn = i[0]; prog = 1'b1;
            @(posedge clk); #1;
            check("t5_hold_reqOut", {31'd0, reqOut}, 32'd1);
            check("t5_hold_data", {16'd0, dataOut}, {16'd0, exp});
            check("t5_hold_reqIn", {31'd0, reqIn}, 32'd0);
            check("t5_hold_key", {16'd0, key}, 32'h0001);
        end
        rdyIn = 1'b0; prog = 1'b0;
        take_output("t5");

        m_key = 16'h0001;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) begin
                m_key = DW'($urandom);
                send(m_key, RW'($urandom), 1'b0, 1'b1);
                check("rnd_key", {16'd0, key}, {16'd0, m_key});
            end
            d   = DW'($urandom);
            off = RW'($urandom);
            md  = 1'($urandom);
            exp = model(d, m_key, int'(off), dec_effective(md));
            send(d, off, md, 1'b0);
            await_result("rnd", exp);
            held = dataOut;
            repeat ($urandom_range(3)) @(posedge clk);
            #1 check("rnd_stable", {16'd0, dataOut}, {16'd0, held});
            take_output("rnd");
`ifdef ENCRYPTER_DECRYPT_EN
            send(exp, off, 1'b1, 1'b0);
            await_result("rnd_roundtrip", d);
            take_output("rnd_rt");
`endif
        end

        // Reset while a word is mid-flight.
        send(16'hBEEF, 4'd5, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t7_reqIn", {31'd0, reqIn}, 32'd1);
        check("t7_reqOut", {31'd0, reqOut}, 32'd0);
        check("t7_dataOut", {16'd0, dataOut}, 32'd0);
        check("t7_key", {16'd0, key}, 32'd0);
        check("t7_state", {30'd0, state}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rot_cipher.md
# rot_cipher

Parametrised multi-round key-rotation cipher engine, the next generation of the single-round encrypter on the data path. Accepts words (or a key) over a req/rdy handshake, runs ROUNDS iterations of XOR with a rotated key plus a 1-bit data rotation, one round per clock, and returns the result over a second req/rdy handshake. Decrypt mode inverts the transform with the same key and offset.

## Interface
- DATA_WIDTH, 16: data and key width; power of two, ≥4.
- ROT_WIDTH, 4: rotation offset width; must equal log2(DATA_WIDTH).
- ROUNDS, 2: rounds per word, 1..16.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  DATA_WIDTH  plaintext/ciphertext word, or key when prog=1.
- rot_offset  in  ROT_WIDTH  per-word key rotation step.
- mode  in  1  0 = encrypt, 1 = decrypt; see Configuration.
- prog  in  1  sampled on input transfer: 1 = load dataIn as key.
- rdyIn  in  1  upstream has valid dataIn/rot_offset/mode/prog.
- rdyOut  in  1  downstream can take dataOut.
- reqIn  out  1  block can accept an input transfer.
- reqOut  out  1  dataOut valid.
- dataOut  out  DATA_WIDTH  result word.
- state  out  2  IDLE=0, ROUND=1, DONE=2.
- key  out  DATA_WIDTH  current key register.

## Operation
- Input transfer: rising edge with reqIn=1 and rdyIn=1. Output transfer: rising edge with reqOut=1 and rdyOut=1.
- IDLE: reqIn=1. On input transfer with prog=1: key <= dataIn, stay IDLE, no output. With prog=0: latch dataIn, rot_offset, mode; round counter r <= 0; go ROUND.
- Round key k_i = rotl(key, ((i+1)·rot_offset) mod DATA_WIDTH); product truncated to ROT_WIDTH bits (wraps).
- Encrypt, i = 0..ROUNDS-1: d <= rotl(d ^ k_i, 1).
- Decrypt, i = ROUNDS-1..0: d <= rotr(d, 1) ^ k_i.
- ROUND: one round per cycle; after last round go DONE.
- DONE: reqOut=1, dataOut holds result; on output transfer go IDLE. Holds indefinitely while rdyOut=0.
- Key unchanged by data words; only prog transfers and reset write it.
- rdyIn, prog ignored outside IDLE; rdyOut ignored outside DONE.

## Timing
- Reset values: reqIn=1, reqOut=0, dataOut=0, state=IDLE, key=0, r=0.
- Reset mid-ROUND or mid-DONE: word dropped, all reset values on next cycle.
- reqIn falls the cycle after a data transfer; reqOut rises exactly ROUNDS cycles after the transfer edge.
- rdyOut already high when DONE entered: DONE lasts exactly one cycle.
- reqIn returns high the cycle after output transfer; min period ROUNDS+2 cycles/word.
- Key load: one cycle, reqIn stays high; back-to-back key then data accepted on consecutive edges, data uses new key.
- dataOut stable from DONE entry until next data transfer.

## Configuration
- ENCRYPTER_DECRYPT_EN defined: mode sampled, decrypt datapath built.
- Undefined: mode ignored, always encrypt; decrypt logic not synthesised. Port remains.

## Test plan
- Reset, no key, dataIn=0xF0F0, rot_offset=7, encrypt -> dataOut=0xC3C3, reqOut rises 2 cycles after transfer.
- prog=1 dataIn=0x0001, then 0x0000 offset=4 encrypt -> key=0x0001, dataOut=0x0240.
- Same key, 0x0240 offset=4, mode=1 (macro on) -> 0x0000; macro off -> encrypt result.
- Key 0x0001, data 0x0000, offset=15 (wrap) -> 0x8002.
- rdyOut held low 10 cycles -> reqOut/dataOut hold, reqIn=0, rdyIn pulses ignored; rdyOut high -> IDLE next cycle.
- reset asserted during ROUND -> next cycle reqIn=1, reqOut=0, dataOut=0, key=0.
